sgemm_dot_accum: RTL and testbench



---
 rtl/sgemm_dot_accum_if.sv | 45 ++++
 rtl/sgemm_dot_accum.sv | 112 +++++++++++
 tb/tb_sgemm_dot_accum.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sgemm_dot_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : sgemm_dot_accum_if
// Brief    : Bundle of the multiplier-side, pipeline-enable and result
//            handshake signals of the sgemm dot-product accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface sgemm_dot_accum_if #(
  parameter int DATA_WIDTH = 63,
  parameter int CNT_WIDTH  = 16
);
  logic                          mul_ce;
  logic                          in_valid;
  logic                          in_last;
  logic signed [DATA_WIDTH-1:0]  prod;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH-1:0]  out_data;
  logic [CNT_WIDTH-1:0]          out_count;

  // Environment side: operand feeder, multiplier dout and C-tile writeback.
  modport master (
    input  mul_ce,
    output in_valid,
    output in_last,
    output prod,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_count
  );

  // Accumulator side.
  modport slave (
    output mul_ce,
    input  in_valid,
    input  in_last,
    input  prod,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_count
  );
endinterface
`default_nettype wire

// File: rtl/sgemm_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : sgemm_dot_accum
// Brief    : Tracks valid/last tags alongside the pipelined multiplier,
//            accumulates products into one signed dot product per row/column
//            pair, and presents each sum on a ready/valid output. Generates
//            the shared pipeline enable so the multiplier and operand feeder
//            freeze while an unaccepted result is held.
// Revision : 1.0 - initial release
// ============================================================================
module sgemm_dot_accum #(
  parameter int DATA_WIDTH  = 63,  // must equal the multiplier dout width
  parameter int MUL_LATENCY = 4,   // operand sample to product valid, >= 1
  parameter int CNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  sgemm_dot_accum_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  // IDLE means the next valid tail starts a fresh sum.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                        r_state;
  logic [MUL_LATENCY-1:0]        r_tag_v;
  logic [MUL_LATENCY-1:0]        r_tag_l;
  logic signed [DATA_WIDTH-1:0]  r_acc;
  logic [CNT_WIDTH-1:0]          r_cnt;
  logic                          r_out_valid;
  logic signed [DATA_WIDTH-1:0]  r_out_data;
  logic [CNT_WIDTH-1:0]          r_out_count;

  logic                          w_mul_ce;
  logic                          w_first;
  logic                          w_tail_v;
  logic                          w_tail_l;
  logic signed [DATA_WIDTH-1:0]  w_base;
  logic signed [DATA_WIDTH-1:0]  w_sum;
  logic [CNT_WIDTH-1:0]          w_cnt_next;

  // Freeze everything only while a result sits unaccepted; a same-cycle
  // accept keeps the pipeline moving.
  assign w_mul_ce = !(r_out_valid && !bus.out_ready);

  assign w_first  = (r_state == ST_IDLE);
  assign w_tail_v = r_tag_v[MUL_LATENCY-1];
  assign w_tail_l = r_tag_l[MUL_LATENCY-1];

  // Sum wraps modulo 2^DATA_WIDTH, matching the multiplier's truncation.
  assign w_base     = w_first ? '0 : r_acc;
  assign w_sum      = w_base + bus.prod;
  assign w_cnt_next = w_first ? c_cnt_one
                    : ((r_cnt == c_cnt_max) ? c_cnt_max : (r_cnt + c_cnt_one));

  assign bus.mul_ce    = w_mul_ce;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_count = r_out_count;

  // Tag pipe mirrors the multiplier registers; its tail lines up with prod.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v <= '0;
      r_tag_l <= '0;
    end else if (w_mul_ce) begin
      r_tag_v[0] <= bus.in_valid;
      r_tag_l[0] <= bus.in_valid & bus.in_last;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_l[i] <= r_tag_l[i-1];
      end
    end
  end

  // Accumulate FSM with registered result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // With mul_ce high any held result is being accepted this edge, so a
      // new last tail may overwrite the output registers safely.
      if (w_mul_ce && w_tail_v) begin
        if (w_tail_l) begin
          r_out_data  <= w_sum;
          r_out_count <= w_cnt_next;
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end else begin
          r_acc   <= w_sum;
          r_cnt   <= w_cnt_next;
          r_state <= ST_ACCUM;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sgemm_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgemm_dot_accum
// Brief    : Directed self-checking bench for sgemm_dot_accum with a simple
//            enable-gated delay line standing in for the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgemm_dot_accum;

  localparam int DW  = 63;
  localparam int LAT = 4;
  localparam int CW  = 16;

  logic clk;
  logic reset;
  logic signed [DW-1:0] op_prod;
  logic signed [DW-1:0] mpipe [LAT];

  int total;
  int bad;

  sgemm_dot_accum_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  sgemm_dot_accum #(
    .DATA_WIDTH (DW),
    .MUL_LATENCY(LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in: the intended product enters at sampling and emerges
  // LAT enabled edges later, frozen whenever mul_ce is low.
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      mpipe[0] <= op_prod;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign bus.prod = mpipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic signed [DW-1:0] p);
    bus.in_valid = v;
    bus.in_last  = l;
    op_prod      = p;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_data: got %0d expected 0", bus.out_data); end
    total++; if (bus.out_count !== '0) begin bad++; $display("FAIL reset_count: got %0d expected 0", bus.out_count); end
    total++; if (bus.mul_ce !== 1'b1) begin bad++; $display("FAIL reset_ce: got %0b expected 1", bus.mul_ce); end
  endtask

  task automatic test_basic_dot();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 3);   tick();
    drive(1'b1, 1'b0, -5);  tick();
    drive(1'b1, 1'b0, 7);   tick();
    drive(1'b1, 1'b1, 10);  tick();
    drive(1'b0, 1'b0, '0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (bus.out_valid !== (k == 4)) begin bad++; $display("FAIL basic_valid k=%0d: got %0b expected %0b", k, bus.out_valid, (k == 4)); end
      if (k == 4) begin
        total++; if (bus.out_data !== 63'sd15) begin bad++; $display("FAIL basic_data: got %0d expected 15", bus.out_data); end
        total++; if (bus.out_count !== 16'd4) begin bad++; $display("FAIL basic_count: got %0d expected 4", bus.out_count); end
      end
    end
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 63'sh3FFF_FFFF_FFFF_FFFF); tick();
    drive(1'b1, 1'b1, 1);                        tick();
    drive(1'b0, 1'b0, '0);
    for (int k = 1; k <= 4; k++) tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %0b expected 1", bus.out_valid); end
    total++; if (bus.out_data !== 63'h4000_0000_0000_0000) begin bad++; $display("FAIL wrap_data: got %h expected 4000000000000000", bus.out_data); end
    total++; if (bus.out_count !== 16'd2) begin bad++; $display("FAIL wrap_count: got %0d expected 2", bus.out_count); end
    tick();
  endtask

  task automatic test_bubbles();
    // Bubble rows carry in_last with in_valid low, which must be ignored.
    bit tv [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit tl [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int tp [7] = '{1, 0, 0, 0, 2, 0, 4};
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 7) drive(tv[i], tl[i], tp[i]);
      else       drive(1'b0, 1'b0, '0);
      tick();
      total++;
      if (bus.out_valid !== (i == 10)) begin bad++; $display("FAIL bubble_valid i=%0d: got %0b expected %0b", i, bus.out_valid, (i == 10)); end
    end
    total++; if (bus.out_data !== 63'sd7) begin bad++; $display("FAIL bubble_data: got %0d expected 7", bus.out_data); end
    total++; if (bus.out_count !== 16'd3) begin bad++; $display("FAIL bubble_count: got %0d expected 3", bus.out_count); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 9); tick();
    drive(1'b1, 1'b0, 1); tick();
    drive(1'b1, 1'b1, 1); tick();
    drive(1'b0, 1'b0, '0); tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_early_valid: got %0b expected 0", bus.out_valid); end
    tick();
    // Result 9 arrives; a single-term dot of 3 is presented and held upstream.
    drive(1'b1, 1'b1, 3);
    for (int k = 5; k <= 10; k++) begin
      if (k > 5) tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid k=%0d: got %0b expected 1", k, bus.out_valid); end
      total++; if (bus.out_data !== 63'sd9) begin bad++; $display("FAIL bp_hold_data k=%0d: got %0d expected 9", k, bus.out_data); end
      total++; if (bus.mul_ce !== 1'b0) begin bad++; $display("FAIL bp_hold_ce k=%0d: got %0b expected 0", k, bus.mul_ce); end
    end
    total++; if (bus.out_count !== 16'd1) begin bad++; $display("FAIL bp_hold_count: got %0d expected 1", bus.out_count); end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.mul_ce !== 1'b1) begin bad++; $display("FAIL bp_release_ce: got %0b expected 1", bus.mul_ce); end
    tick();
    drive(1'b0, 1'b0, '0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_accept_valid: got %0b expected 0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid: got %0b expected 1", bus.out_valid); end
    total++; if (bus.out_data !== 63'sd2) begin bad++; $display("FAIL bp_second_data: got %0d expected 2", bus.out_data); end
    total++; if (bus.out_count !== 16'd2) begin bad++; $display("FAIL bp_second_count: got %0d expected 2", bus.out_count); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_gap1_valid: got %0b expected 0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_gap2_valid: got %0b expected 0", bus.out_valid); end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_held_valid: got %0b expected 1", bus.out_valid); end
    total++; if (bus.out_data !== 63'sd3) begin bad++; $display("FAIL bp_held_data: got %0d expected 3", bus.out_data); end
    total++; if (bus.out_count !== 16'd1) begin bad++; $display("FAIL bp_held_count: got %0d expected 1", bus.out_count); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 8) drive(1'b1, 1'b1, k);
      else        drive(1'b0, 1'b0, '0);
      tick();
      total++;
      if (bus.out_valid !== (k >= 5)) begin bad++; $display("FAIL b2b_valid k=%0d: got %0b expected %0b", k, bus.out_valid, (k >= 5)); end
      if (k >= 5) begin
        total++; if (bus.out_data !== DW'(k - 4)) begin bad++; $display("FAIL b2b_data k=%0d: got %0d expected %0d", k, bus.out_data, k - 4); end
        total++; if (bus.out_count !== 16'd1) begin bad++; $display("FAIL b2b_count k=%0d: got %0d expected 1", k, bus.out_count); end
      end
    end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 100); tick();
    drive(1'b1, 1'b0, 200); tick();
    drive(1'b0, 1'b0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %0b expected 0", bus.out_valid); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL rmid_data: got %0d expected 0", bus.out_data); end
    total++; if (bus.out_count !== '0) begin bad++; $display("FAIL rmid_count: got %0d expected 0", bus.out_count); end
    total++; if (bus.mul_ce !== 1'b1) begin bad++; $display("FAIL rmid_ce: got %0b expected 1", bus.mul_ce); end
    drive(1'b1, 1'b0, 5); tick();
    drive(1'b1, 1'b1, 6); tick();
    drive(1'b0, 1'b0, '0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (bus.out_valid !== (k == 4)) begin bad++; $display("FAIL rmid_fresh_valid k=%0d: got %0b expected %0b", k, bus.out_valid, (k == 4)); end
      if (k == 4) begin
        total++; if (bus.out_data !== 63'sd11) begin bad++; $display("FAIL rmid_fresh_data: got %0d expected 11", bus.out_data); end
        total++; if (bus.out_count !== 16'd2) begin bad++; $display("FAIL rmid_fresh_count: got %0d expected 2", bus.out_count); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0);
    test_reset();
    test_basic_dot();
    test_wrap();
    test_bubbles();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
